// File: rtl/modulation_pkg.sv
// Shared types for the modulation sample BRAM write path.
// One FIFO entry is a CPU word plus the page/offset it was written to.
package modulation_pkg;

  localparam int ADDR_W     = 16;
  localparam int WIN_W      = 13;
  localparam int PAGE_W     = ADDR_W - WIN_W - 1;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [PAGE_W-1:0] page;
    logic [WIN_W-1:0]  waddr;
    logic [15:0]       wdata;
  } mod_wr_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } mod_wr_state_t;

  // Byte address is a plain concatenation; no carry ever crosses a field.
  function automatic logic [ADDR_W-1:0] byte_addr(input mod_wr_entry_t e, input logic odd);
    return {e.page, e.waddr, odd};
  endfunction

endpackage

// File: rtl/modulation_write_fifo.sv
// Small show-ahead synchronous FIFO of CPU write entries.
// Push is ignored when full and pop when empty; the head is visible on dout_o.
module modulation_write_fifo
  import modulation_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_i,
  input  mod_wr_entry_t din_i,
  input  logic          pop_i,
  output mod_wr_entry_t dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  mod_wr_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/modulation_writer.sv
// Write-side front end of the modulation sample BRAM: buffers CPU words,
// splits them into byte writes and publishes CYCLE once all prior writes land.
module modulation_writer #(
  parameter  int ADDR_W     = 16,
  parameter  int WIN_W      = 13,
  parameter  int FIFO_DEPTH = 4,
  localparam int PAGE_W     = ADDR_W - WIN_W - 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [WIN_W-1:0]  WADDR,
  input  logic [15:0]       WDATA,
  input  logic [PAGE_W-1:0] PAGE,
  input  logic              CYCLE_WE,
  input  logic [15:0]       CYCLE_IN,
  output logic              READY,
  output logic              OVF,
  output logic              BRAM_WE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [7:0]        BRAM_DIN,
  output logic [15:0]       CYCLE,
  output logic              UPDATE
);

  import modulation_pkg::*;

  mod_wr_state_t     state_q, state_d;
  mod_wr_entry_t     hold_q, hold_d;
  mod_wr_entry_t     push_entry, fifo_head;
  logic              fifo_full, fifo_empty, push, pop;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic [15:0]       pend_cycle_q, pend_cycle_d;
  logic [15:0]       cycle_q, cycle_d;
  logic              update_q, update_d;
  logic              pend_eff, commit;

  assign push_entry = '{page: PAGE, waddr: WADDR, wdata: WDATA};
  assign READY      = ~fifo_full;
  assign push       = WE & READY;

  modulation_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // state_q names the byte currently on the BRAM port; outputs for the next one are prepared here.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bram_we_d = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    pop       = 1'b0;
    case (state_q)
      IDLE, HI: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          hold_d    = fifo_head;
          bram_we_d = 1'b1;
          addr_d    = byte_addr(fifo_head, 1'b0);
          din_d     = fifo_head.wdata[7:0];
          state_d   = LO;
        end else begin
          state_d   = IDLE;
        end
      end
      LO: begin
        bram_we_d = 1'b1;
        addr_d    = byte_addr(hold_q, 1'b1);
        din_d     = hold_q.wdata[15:8];
        state_d   = HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // A commit may publish in the same edge as the final HI byte, since both land together.
  always_comb begin
    pend_eff     = pend_q | CYCLE_WE;
    pend_cycle_d = CYCLE_WE ? CYCLE_IN : pend_cycle_q;
    commit       = pend_eff & fifo_empty & ~push & (state_d == IDLE);
    pend_d       = pend_eff & ~commit;
    cycle_d      = commit ? pend_cycle_d : cycle_q;
    update_d     = commit;
    ovf_d        = ovf_q | (WE & ~READY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      bram_we_q    <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_cycle_q <= '0;
      cycle_q      <= '0;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bram_we_q    <= bram_we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      ovf_q        <= ovf_d;
      pend_q       <= pend_d;
      pend_cycle_q <= pend_cycle_d;
      cycle_q      <= cycle_d;
      update_q     <= update_d;
    end
  end

  always_ff @(posedge CLK) begin
    hold_q <= hold_d;
  end

  assign OVF       = ovf_q;
  assign BRAM_WE   = bram_we_q;
  assign BRAM_ADDR = addr_q;
  assign BRAM_DIN  = din_q;
  assign CYCLE     = cycle_q;
  assign UPDATE    = update_q;

endmodule
